// File: rtl/axi4_lite_if_pkg.sv
// Shared AXI4-Lite types: response codes, command-master FSM states and a
// command struct/helper used to build stimulus for the command master.
package axi4_lite_if_pkg;

    typedef enum logic [1:0] {
        AXI4_RESP_OKAY   = 2'b00,
        AXI4_RESP_EXOKAY = 2'b01,
        AXI4_RESP_SLVERR = 2'b10,
        AXI4_RESP_DECERR = 2'b11
    } axi4_resp_t;

    localparam axi4_resp_t RESP_SLVERR = AXI4_RESP_SLVERR;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } axi4_lite_cmd_mst_state_t;

    // Sized for the widest legal configuration; narrower users truncate.
    typedef struct packed {
        logic        is_write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [2:0]  prot;
    } axi4_lite_cmd_t;

    function automatic axi4_lite_cmd_t make_cmd(
        input logic        is_write,
        input logic [63:0] addr,
        input logic [63:0] wdata,
        input logic [7:0]  wstrb,
        input logic [2:0]  prot
    );
        axi4_lite_cmd_t c;
        c.is_write = is_write;
        c.addr     = addr;
        c.wdata    = wdata;
        c.wstrb    = wstrb;
        c.prot     = prot;
        return c;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if
    import axi4_lite_if_pkg::*;
#(
    parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32
) ();

    logic                                    awvalid;
    logic                                    awready;
    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]     awaddr;
    logic [2:0]                              awprot;
    logic                                    wvalid;
    logic                                    wready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]     wdata;
    logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0]   wstrb;
    logic                                    bvalid;
    logic                                    bready;
    axi4_resp_t                              bresp;
    logic                                    arvalid;
    logic                                    arready;
    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]     araddr;
    logic [2:0]                              arprot;
    logic                                    rvalid;
    logic                                    rready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]     rdata;
    axi4_resp_t                              rresp;

    modport mst_port (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slv_port (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// Single-outstanding command/response to AXI4-Lite master bridge.
// Optional watchdog: define AXI4_LITE_CMD_MST_TIMEOUT_EN.
module axi4_lite_cmd_mst
    import axi4_lite_if_pkg::*;
#(
    parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES           = 256
) (
    input  logic                                  i_clk,
    input  logic                                  i_arst_n,
    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic                                  i_cmd_is_write,
    input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
    input  logic [2:0]                            i_cmd_prot,
    output logic                                  o_rsp_valid,
    input  logic                                  i_rsp_ready,
    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                            o_rsp_resp,
    output logic                                  o_rsp_timeout,
    axi4_lite_if.mst_port                         if_m_axi4_lite
);

    localparam int unsigned AW = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int unsigned DW = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int unsigned SW = DW / 8;

    if (!(DW == 32 || DW == 64) || TIMEOUT_CYCLES < 2) begin : g_cfg_err
        $error("axi4_lite_cmd_mst: unsupported DATA width or TIMEOUT_CYCLES");
    end

    axi4_lite_cmd_mst_state_t state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    axi4_resp_t       rsp_resp_q, rsp_resp_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic [2:0]       prot_q, prot_d;

`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= AXI4_RESP_OKAY;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Every output is the registered form of these next values.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    addr_d      = i_cmd_addr;
                    wdata_d     = i_cmd_wdata;
                    wstrb_d     = i_cmd_wstrb;
                    prot_d      = i_cmd_prot;
                    cmd_ready_d = 1'b0;
                    if (i_cmd_is_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; move on once both are gone.
                if (if_m_axi4_lite.awready) awvalid_d = 1'b0;
                if (if_m_axi4_lite.wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (if_m_axi4_lite.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = if_m_axi4_lite.bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (if_m_axi4_lite.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (if_m_axi4_lite.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = if_m_axi4_lite.rdata;
                    rsp_resp_d  = if_m_axi4_lite.rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
        if (state_q == ST_IDLE && i_cmd_valid) begin
            wd_d      = '0;
            timeout_d = 1'b0;
        end else if (state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_DATA}) begin
            wd_d = wd_q + 1'b1;
            // Watchdog overrides any handshake on the same edge.
            if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_resp_d  = RESP_SLVERR;
                rsp_rdata_d = '0;
                timeout_d   = 1'b1;
                state_d     = ST_RSP;
            end
        end
`endif
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_resp  = rsp_resp_q;
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
    assign o_rsp_timeout = timeout_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

    assign if_m_axi4_lite.awvalid = awvalid_q;
    assign if_m_axi4_lite.awaddr  = addr_q;
    assign if_m_axi4_lite.awprot  = prot_q;
    assign if_m_axi4_lite.wvalid  = wvalid_q;
    assign if_m_axi4_lite.wdata   = wdata_q;
    assign if_m_axi4_lite.wstrb   = wstrb_q;
    assign if_m_axi4_lite.bready  = bready_q;
    assign if_m_axi4_lite.arvalid = arvalid_q;
    assign if_m_axi4_lite.araddr  = addr_q;
    assign if_m_axi4_lite.arprot  = prot_q;
    assign if_m_axi4_lite.rready  = rready_q;

endmodule
